mult_seq_param: RTL and testbench

- Parametrised sequential shift-and-add multiplier with integrated control and datapath. Successor to the fixed-width multiplier core.
- Supports runtime-selectable signed (two's complement) or unsigned operands.
- Terminates early once the remaining multiplier bits are zero, and signals with a ready/init/done handshake.
- Sits behind the SoC peripheral wrapper, which writes the operands, pulses init, polls done and reads result.

---
 rtl/mult_seq_param.sv | 125 ++++++++++++
 tb/tb_mult_seq_param.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_param.sv
// mult_seq_param
// Sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH, with
// runtime-selectable signed (two's complement) or unsigned operands.
// Magnitudes are multiplied and the sign is applied at the end. The loop
// stops as soon as the remaining multiplier bits are all zero.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset; aborts any operation
//   init         start request, sampled only while ready=1
//   signed_mode  1 = two's complement operands, 0 = unsigned (sampled with init)
//   op_a         multiplicand (sampled with init)
//   op_b         multiplier (sampled with init)
//   ready        high only in IDLE
//   busy         high in RUN and SIGN
//   done         one-cycle pulse when result becomes valid
//   result       product, held until overwritten by the next operation or rst
//
// state | meaning
// IDLE  | waiting for init; operands are latched on init
// RUN   | one shift-and-add iteration per cycle
// SIGN  | apply the sign to the accumulated magnitude
// DONE  | result valid, done pulse
module mult_seq_param #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    state_t               state;
    logic [2*WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [2*WIDTH-1:0]   acc;
    logic                 neg;

    logic                 neg_a;
    logic                 neg_b;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;

    // The most negative operand negates to itself, which read as unsigned is
    // exactly its magnitude, so no extra bit is needed.
    assign neg_a = signed_mode & op_a[WIDTH-1];
    assign neg_b = signed_mode & op_b[WIDTH-1];
    assign abs_a = neg_a ? (~op_a + ONE_W) : op_a;
    assign abs_b = neg_b ? (~op_b + ONE_W) : op_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            result <= '0;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (init) begin
                        a_reg <= {{WIDTH{1'b0}}, abs_a};
                        b_reg <= abs_b;
                        acc   <= '0;
                        neg   <= neg_a ^ neg_b;
                        state <= RUN;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    // Product of two WIDTH-bit magnitudes fits in 2*WIDTH bits,
                    // so the accumulator cannot carry out.
                    if (b_reg[0]) begin
                        acc <= acc + a_reg;
                    end
                    a_reg <= a_reg << 1;
                    b_reg <= b_reg >> 1;
                    // Bit 0 is consumed this cycle; stop when nothing above it remains.
                    if (b_reg[WIDTH-1:1] == '0) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    result <= neg ? (~acc + ONE_2W) : acc;
                    state  <= DONE;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_param.sv
module tb_mult_seq_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  init_vec = 3'b000;
    logic        sm = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;

    logic        ready8, busy8, done8;
    logic [15:0] r8;
    logic        ready32, busy32, done32;
    logic [63:0] r32;
    logic        ready5, busy5, done5;
    logic [9:0]  r5;

    always #5 clk = ~clk;

    mult_seq_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .init(init_vec[0]), .signed_mode(sm),
        .op_a(op_a[7:0]), .op_b(op_b[7:0]),
        .ready(ready8), .busy(busy8), .done(done8), .result(r8));

    mult_seq_param #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .init(init_vec[1]), .signed_mode(sm),
        .op_a(op_a), .op_b(op_b),
        .ready(ready32), .busy(busy32), .done(done32), .result(r32));

    mult_seq_param #(.WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .init(init_vec[2]), .signed_mode(sm),
        .op_a(op_a[4:0]), .op_b(op_b[4:0]),
        .ready(ready5), .busy(busy5), .done(done5), .result(r5));

    // sel: 0 -> WIDTH 8, 1 -> WIDTH 32, 2 -> WIDTH 5
    int          cur = 0;
    logic        cur_ready, cur_busy, cur_done;
    logic [63:0] cur_result;

    always_comb begin
        cur_ready  = ready8;
        cur_busy   = busy8;
        cur_done   = done8;
        cur_result = {48'd0, r8};
        if (cur == 1) begin
            cur_ready  = ready32;
            cur_busy   = busy32;
            cur_done   = done32;
            cur_result = r32;
        end else if (cur == 2) begin
            cur_ready  = ready5;
            cur_busy   = busy5;
            cur_done   = done5;
            cur_result = {54'd0, r5};
        end
    end

    typedef struct {
        logic [63:0] res;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    function automatic int width_of(int sel);
        return (sel == 1) ? 32 : ((sel == 2) ? 5 : 8);
    endfunction

    function automatic logic [63:0] ref_mul(int w, bit s, logic [31:0] a, logic [31:0] b);
        logic [63:0] mask, mask2, am, bm;
        longint      sa, sb;
        mask  = (w == 32) ? 64'h0000_0000_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        mask2 = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
        am = {32'd0, a} & mask;
        bm = {32'd0, b} & mask;
        if (s) begin
            sa = am[w-1] ? (longint'(am) - (longint'(1) << w)) : longint'(am);
            sb = bm[w-1] ? (longint'(bm) - (longint'(1) << w)) : longint'(bm);
            return 64'(sa * sb) & mask2;
        end
        return (am * bm) & mask2;
    endfunction

    function automatic int ref_lat(int w, bit s, logic [31:0] b);
        logic [63:0] bm, absb;
        int k;
        bm = {32'd0, b} & ((w == 32) ? 64'h0000_0000_FFFF_FFFF : ((64'd1 << w) - 64'd1));
        absb = (s && bm[w-1]) ? ((64'd1 << w) - bm) : bm;
        k = 0;
        for (int i = 0; i < w; i++) begin
            if (absb[i]) k = i;
        end
        return k + 3;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one accept cycle (cycle 0) and leaves the bench in cycle 1.
    task automatic start_op(int sel, bit s, logic [31:0] a, logic [31:0] b, bit keep);
        int n;
        exp_t e;
        cur = sel;
        #0;
        n = 0;
        while (!cur_ready && n < 100) begin
            step();
            n++;
        end
        if (!cur_ready) check("ready_wait", 64'(cur_ready), 64'd1);
        sm   = s;
        op_a = a;
        op_b = b;
        init_vec[sel] = 1'b1;
        e.res = ref_mul(width_of(sel), s, a, b);
        e.lat = ref_lat(width_of(sel), s, b);
        exp_q.push_back(e);
        step();
        if (!keep) init_vec[sel] = 1'b0;
    endtask

    // Called in cycle 1; returns in the done cycle.
    task automatic finish_op(string tag, bit noise, bit keep);
        int   cnt;
        bit   busy_ok;
        exp_t e;
        cnt = 1;
        busy_ok = 1'b1;
        while (!cur_done && cnt < 60) begin
            if (!cur_busy || cur_ready) busy_ok = 1'b0;
            if (noise) begin
                init_vec[cur] = 1'($urandom_range(0, 1));
                op_a = $urandom;
                op_b = $urandom;
                sm   = 1'($urandom_range(0, 1));
            end
            step();
            cnt++;
        end
        if (!keep) init_vec[cur] = 1'b0;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_result"}, cur_result, e.res);
            check({tag, "_latency"}, 64'(cnt), 64'(e.lat));
            check({tag, "_busy"}, {63'd0, busy_ok}, 64'd1);
        end
    endtask

    // Steps past the done cycle and checks the pulse was one cycle wide.
    task automatic end_op(string tag);
        step();
        check({tag, "_done_width"}, {62'd0, cur_done, cur_ready}, 64'd1);
    endtask

    task automatic run_op(string tag, int sel, bit s, logic [31:0] a, logic [31:0] b, bit noise);
        start_op(sel, s, a, b, 1'b0);
        finish_op(tag, noise, 1'b0);
        end_op(tag);
    endtask

    initial begin
        bit   seen_done;
        exp_t dummy;

        cur = 0;
        rst = 1'b1;
        step();
        step();
        check("rst_outputs", {45'd0, ready8, busy8, done8, r8}, {45'd0, 3'b100, 16'h0000});
        rst = 1'b0;
        step();

        run_op("u_full",   0, 1'b0, 32'hC8, 32'hFF, 1'b0);
        check("u_full_const", {48'd0, r8}, 64'hC738);
        run_op("s_ext",    0, 1'b1, 32'h80, 32'h80, 1'b0);
        check("s_ext_const", {48'd0, r8}, 64'h4000);
        run_op("s_m3x5",   0, 1'b1, 32'hFD, 32'h05, 1'b0);
        check("s_m3x5_const", {48'd0, r8}, 64'hFFF1);
        run_op("u_early",  0, 1'b0, 32'hFF, 32'h02, 1'b0);
        run_op("u_bzero",  0, 1'b0, 32'h4D, 32'h00, 1'b0);
        run_op("s_bzero",  0, 1'b1, 32'h80, 32'h00, 1'b0);
        run_op("s_azero",  0, 1'b1, 32'h00, 32'hF3, 1'b0);
        run_op("noise",    0, 1'b1, 32'h9C, 32'hB7, 1'b1);

        // init held high across two operations
        start_op(0, 1'b0, 32'h35, 32'h6B, 1'b1);
        finish_op("hold1", 1'b0, 1'b1);
        op_a = 32'hF0;
        op_b = 32'h11;
        sm   = 1'b1;
        begin
            exp_t e2;
            e2.res = ref_mul(8, 1'b1, 32'hF0, 32'h11);
            e2.lat = ref_lat(8, 1'b1, 32'h11);
            exp_q.push_back(e2);
        end
        step();
        check("hold_ready_one", {62'd0, cur_ready, cur_done}, 64'd2);
        step();
        check("hold_ready_off", {62'd0, cur_ready, cur_busy}, 64'd1);
        finish_op("hold2", 1'b0, 1'b0);
        end_op("hold2");

        // reset in cycle 3 of a long run
        start_op(0, 1'b0, 32'hC8, 32'hFF, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_state", {45'd0, ready8, busy8, done8, r8}, {45'd0, 3'b100, 16'h0000});
        seen_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (done8) seen_done = 1'b1;
            step();
        end
        check("midrst_no_done", {63'd0, seen_done}, 64'd0);
        dummy = exp_q.pop_front();
        run_op("after_rst", 0, 1'b0, 32'hC8, 32'hFF, 1'b0);

        for (int i = 0; i < 300; i++) run_op("rnd8",  0, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0);
        for (int i = 0; i < 300; i++) run_op("rnd5",  2, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0);
        run_op("w32_min",  1, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op("w5_min",   2, 1'b1, 32'h10, 32'h10, 1'b0);
        for (int i = 0; i < 300; i++) run_op("rnd32", 1, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
